// File: rtl/uart_ctrl_pkg.sv
// Shared encodings, default constants and width helpers for the UART transmit scheduler.
package uart_ctrl_pkg;

    localparam int unsigned DEF_BAUD_DIV = 1042;
    localparam int unsigned GRANT_W      = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT_HI = 3'd2;
    localparam logic [2:0] ST_WAIT_LO = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        ISSUE   = ST_ISSUE,
        WAIT_HI = ST_WAIT_HI,
        WAIT_LO = ST_WAIT_LO,
        GAP     = ST_GAP
    } state_e;

    // Bits needed to index n requesters (at least one).
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold values 0..maxval (at least one).
    function automatic int unsigned cnt_width(input int unsigned maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Trigger-side and transmitter-side signals of the UART transmit scheduler.
interface uart_tx_sched_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]              req;
    logic                            tx_busy;
    logic                            baud_tick;
    logic                            send;
    logic [uart_ctrl_pkg::GRANT_W-1:0] grant_id;
    logic                            active;
    logic [NUM_REQ-1:0]              pending;
    logic [7:0]                      tx_count;
    logic                            timeout_err;

    modport master (
        input  req, tx_busy,
        output baud_tick, send, grant_id, active, pending, tx_count, timeout_err
    );

    modport slave (
        output req, tx_busy,
        input  baud_tick, send, grant_id, active, pending, tx_count, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler_baud.sv
// Free-running baud tick generator; tick is high while the count sits at BAUD_DIV-1.
module baud_gen
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int unsigned CNT_W = cnt_width(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Next count wraps at BAUD_DIV-1; tick registered to coincide with the terminal count.
    always_comb begin
        cnt_d  = (cnt_q == CNT_W'(BAUD_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_d == CNT_W'(BAUD_DIV - 1));
    end

    // Counter and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one hardcoded-message UART transmitter between requesters.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BAUD_DIV     = DEF_BAUD_DIV,
    parameter int unsigned GAP_TICKS    = 2,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_sched_if.master bus
);
    localparam int unsigned PTR_W = id_width(NUM_REQ);
    localparam int unsigned TMO_W = cnt_width(BUSY_TIMEOUT);
    localparam int unsigned GAP_W = cnt_width(GAP_TICKS);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_q, rr_d, grant_q, grant_d, pick_c;
    logic [NUM_REQ-1:0] pending_q, pending_d, clr_c;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         count_q, count_d;
    logic               err_q, err_d;
    logic               send_q, send_d;
    logic               active_q, active_d;
    logic               tick;

    baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // First set bit at or after ptr, wrapping around.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] pend,
                                                 input logic [PTR_W-1:0]   ptr);
        logic [PTR_W-1:0] pick;
        logic [PTR_W-1:0] cand;
        logic             found;
        int unsigned      idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx  = (32'(ptr) + k) % NUM_REQ;
            cand = PTR_W'(idx);
            if (!found && pend[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Arbitration candidate from the latched requests.
    always_comb pick_c = rr_pick(pending_q, rr_q);

    // Next state, counters, pending update and registered-output next values.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        clr_c   = '0;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        count_d = count_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    grant_d       = pick_c;
                    clr_c[pick_c] = 1'b1;
                    rr_d          = (32'(pick_c) == NUM_REQ - 1) ? '0 : pick_c + PTR_W'(1);
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = TMO_W'(BUSY_TIMEOUT);
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end else if (tmo_q <= TMO_W'(1)) begin
                    err_d   = 1'b1;
                    gap_d   = GAP_W'(GAP_TICKS);
                    state_d = GAP;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    count_d = count_q + 8'd1;
                    gap_d   = GAP_W'(GAP_TICKS);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (GAP_TICKS == 0) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (gap_q <= GAP_W'(1)) state_d = IDLE;
                    else                    gap_d   = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A request arriving in its own grant cycle wins over the clear.
        pending_d = (pending_q & ~clr_c) | bus.req;
        send_d    = (state_d == ISSUE);
        active_d  = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            pending_q <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            send_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            count_q   <= count_d;
            err_q     <= err_d;
            send_q    <= send_d;
            active_q  <= active_d;
        end
    end

    assign bus.baud_tick   = tick;
    assign bus.send        = send_q;
    assign bus.grant_id    = GRANT_W'(grant_q);
    assign bus.active      = active_q;
    assign bus.pending     = pending_q;
    assign bus.tx_count    = count_q;
    assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with BAUD_DIV=4, GAP_TICKS=2, BUSY_TIMEOUT=8.
module tb_uart_tx_scheduler;

    logic clk;
    logic rst_n;
    int   cyc;

    uart_tx_sched_if #(.NUM_REQ(4)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ     (4),
        .BAUD_DIV    (4),
        .GAP_TICKS   (2),
        .BUSY_TIMEOUT(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index: 0 is the cycle in which reset is released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Send monitor: counts pulses, logs grant ids and flags sends while busy.
    int   send_cnt = 0;
    int   overlap  = 0;
    logic send_seen = 1'b0;
    int   grant_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                send_seen = bus.send;
                if (bus.send) begin
                    send_cnt++;
                    grant_log.push_back(int'(bus.grant_id));
                    if (bus.tx_busy) overlap++;
                end
            end else begin
                send_seen = 1'b0;
            end
        end
    end

    // Transmitter model: busy rises the cycle after send and stays up busy_hold cycles.
    int   busy_hold = 40;
    int   busy_left = 0;
    logic model_en  = 1'b1;

    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) bus.tx_busy = 1'b0;
            end else if (send_seen && model_en && rst_n) begin
                bus.tx_busy = 1'b1;
                busy_left   = busy_hold;
            end
        end
    end

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.tx_busy = 1'b0;
        busy_left   = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_cnt = 0;
        grant_log.delete();
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        #1;
        bus.req = '0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       tick;
        logic       send;
        logic       active;
        logic [3:0] pend;
        logic [2:0] grant;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int guard;
        int s0;
        int exp_ids[$];

        // Watchdog.
        fork
            begin
                #2_000_000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // ---------- reset, baud tick and single request (table) ----------
        for (int i = 0; i < 16; i++)
            vecs[i] = '{4'b0000, 1'((i % 4) == 3), 1'b0, 1'b0, 4'b0000, 3'd0};
        vecs[10].req  = 4'b0001;
        vecs[11].pend = 4'b0001;
        vecs[12].send = 1'b1;
        for (int i = 12; i < 16; i++) vecs[i].active = 1'b1;

        busy_hold = 40;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.req = vecs[i].req;
            @(negedge clk);
            chk($sformatf("v%0d_tick", i),   32'(bus.baud_tick), 32'(vecs[i].tick));
            chk($sformatf("v%0d_send", i),   32'(bus.send),      32'(vecs[i].send));
            chk($sformatf("v%0d_active", i), 32'(bus.active),    32'(vecs[i].active));
            chk($sformatf("v%0d_pending", i),32'(bus.pending),   32'(vecs[i].pend));
            chk($sformatf("v%0d_grant", i),  32'(bus.grant_id),  32'(vecs[i].grant));
            chk($sformatf("v%0d_count", i),  32'(bus.tx_count),  32'(0));
            @(posedge clk);
            #1;
        end
        bus.req = '0;

        // busy high 13..52, completion visible in 54, ticks at 55 and 59, active low at 60
        guard = 0;
        while (bus.tx_count != 8'd1 && guard < 200) begin @(negedge clk); guard++; end
        chk("single_count_cycle", 32'(cyc), 32'(54));
        guard = 0;
        s0    = 0;
        while (bus.active && guard < 200) begin
            if (bus.baud_tick) s0++;
            @(negedge clk);
            guard++;
        end
        chk("single_gap_ticks", 32'(s0), 32'(2));
        chk("single_active_fall", 32'(cyc), 32'(60));
        chk("single_count", 32'(bus.tx_count), 32'(1));
        chk("single_err", 32'(bus.timeout_err), 32'(0));

        // ---------- simultaneous requests ----------
        @(posedge clk); #1;
        busy_hold = 12;
        do_reset();
        tick_to(5);
        pulse(4'b1111);
        guard = 0;
        while (!(bus.tx_count == 8'd4 && !bus.active) && guard < 3000) begin @(negedge clk); guard++; end
        chk("all4_done", 32'(bus.tx_count == 8'd4 && !bus.active), 32'(1));
        chk("all4_sends", 32'(send_cnt), 32'(4));
        exp_ids = '{0, 1, 2, 3};
        for (int i = 0; i < 4; i++)
            chk($sformatf("all4_grant%0d", i), 32'((grant_log.size() > i) ? grant_log[i] : -1), 32'(exp_ids[i]));
        chk("all4_pending", 32'(bus.pending), 32'(0));

        // ---------- round-robin fairness with re-pulse in grant cycle ----------
        @(posedge clk); #1;
        do_reset();
        tick_to(5);
        pulse(4'b0010);
        guard = 0;
        while (send_cnt < 1 && guard < 100) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        pulse(4'b0101);
        guard = 0;
        while (bus.active && guard < 500) begin @(negedge clk); guard++; end
        chk("rr_pending_pre", 32'(bus.pending), 32'(4'b0101));
        bus.req = 4'b0100;
        @(posedge clk); #1;
        bus.req = '0;
        @(negedge clk);
        chk("rr_pending_repulse", 32'(bus.pending), 32'(4'b0101));
        chk("rr_send_grant2", 32'({bus.send, bus.grant_id}), 32'({1'b1, 3'd2}));
        guard = 0;
        while (!(send_cnt == 4 && !bus.active) && guard < 3000) begin @(negedge clk); guard++; end
        exp_ids = '{1, 2, 0, 2};
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_grant%0d", i), 32'((grant_log.size() > i) ? grant_log[i] : -1), 32'(exp_ids[i]));
        chk("rr_count", 32'(bus.tx_count), 32'(4));
        chk("rr_pending_end", 32'(bus.pending), 32'(0));

        // ---------- busy timeout ----------
        @(posedge clk); #1;
        do_reset();
        model_en = 1'b0;
        tick_to(10);
        pulse(4'b0011);
        tick_to(20);
        @(negedge clk);
        chk("tmo_err_early", 32'(bus.timeout_err), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("tmo_err_set", 32'(bus.timeout_err), 32'(1));
        chk("tmo_active", 32'(bus.active), 32'(1));
        guard = 0;
        while (!(send_cnt == 2 && !bus.active && bus.pending == 4'b0) && guard < 500) begin @(negedge clk); guard++; end
        exp_ids = '{0, 1};
        for (int i = 0; i < 2; i++)
            chk($sformatf("tmo_grant%0d", i), 32'((grant_log.size() > i) ? grant_log[i] : -1), 32'(exp_ids[i]));
        chk("tmo_count", 32'(bus.tx_count), 32'(0));
        chk("tmo_err_sticky", 32'(bus.timeout_err), 32'(1));
        model_en = 1'b1;

        // ---------- tx_count wrap ----------
        @(posedge clk); #1;
        busy_hold = 3;
        do_reset();
        tick_to(3);
        s0 = 1;
        for (int n = 0; n < 256; n++) begin
            pulse(4'b0001);
            guard = 0;
            while (!(bus.tx_count == 8'(n + 1) && !bus.active) && guard < 100) begin @(negedge clk); guard++; end
            if (guard >= 100) begin
                s0 = 0;
                break;
            end
            @(posedge clk); #1;
        end
        chk("wrap_all_done", 32'(s0), 32'(1));
        chk("wrap_sends", 32'(send_cnt), 32'(256));
        chk("wrap_count", 32'(bus.tx_count), 32'(0));

        // ---------- asynchronous abort during WAIT_LO ----------
        busy_hold = 20;
        do_reset();
        tick_to(5);
        pulse(4'b0001);
        guard = 0;
        while (!(bus.tx_count == 8'd1 && !bus.active) && guard < 200) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        pulse(4'b0010);
        guard = 0;
        while (!bus.tx_busy && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        pulse(4'b1000);
        repeat (2) @(negedge clk);
        chk("abort_pre_pending", 32'(bus.pending), 32'(4'b1000));
        chk("abort_pre_grant", 32'(bus.grant_id), 32'(1));
        chk("abort_pre_count", 32'(bus.tx_count), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_tick",    32'(bus.baud_tick),   32'(0));
        chk("abort_send",    32'(bus.send),        32'(0));
        chk("abort_grant",   32'(bus.grant_id),    32'(0));
        chk("abort_active",  32'(bus.active),      32'(0));
        chk("abort_pending", 32'(bus.pending),     32'(0));
        chk("abort_count",   32'(bus.tx_count),    32'(0));
        chk("abort_err",     32'(bus.timeout_err), 32'(0));
        busy_left   = 0;
        bus.tx_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        s0 = send_cnt;
        repeat (20) @(negedge clk);
        chk("abort_no_send", 32'(send_cnt), 32'(s0));
        chk("abort_idle_pending", 32'(bus.pending), 32'(0));
        chk("abort_idle_active", 32'(bus.active), 32'(0));

        chk("send_busy_overlap", 32'(overlap), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
